execute_muldiv_unit: RTL and testbench

- Multi-cycle multiply/divide engine in the execute stage. It consumes SrcAE/SrcBE and the operation code delivered by the decode-to-execute pipeline register.
- Owns the architectural HI/LO registers and raises a busy/stall request so the hazard logic holds fetch/decode and clears the D/E register while an operation is in flight.
- Multiply uses iterative radix-2 shift-add; divide uses radix-2 restoring division; signed forms use magnitude-then-fix.

---
 rtl/execute_muldiv_unit_pkg.sv | 21 ++
 rtl/execute_muldiv_unit_datapath.sv | 119 +++++++++++
 rtl/execute_muldiv_unit.sv | 133 +++++++++++++
 tb/tb_execute_muldiv_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/execute_muldiv_unit_pkg.sv
// Shared definitions for the execute-stage multiply/divide engine:
// operation codes, FSM state encoding and the divide-by-zero quotient.
package execute_muldiv_unit_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } muldiv_state_e;

    // Wide enough for any operand width in use; sliced to DATA_WIDTH.
    localparam logic [127:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/execute_muldiv_unit_datapath.sv
// Arithmetic core of the mul/div engine: operand magnitudes, the 2*W accumulator,
// one shift-add / restoring-divide iteration per step, and the final sign fix.
module muldiv_datapath
    import execute_muldiv_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  i_Load,
    input  logic                  i_Step,
    input  logic [1:0]            i_Op,
    input  logic [DATA_WIDTH-1:0] i_SrcA,
    input  logic [DATA_WIDTH-1:0] i_SrcB,
    output logic [DATA_WIDTH-1:0] o_HiResult,
    output logic [DATA_WIDTH-1:0] o_LoResult
);

    logic [1:0]              r_op;
    logic [2*DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0]   r_opA;
    logic [DATA_WIDTH-1:0]   r_opB;
    logic [DATA_WIDTH-1:0]   r_origA;
    logic                    r_signQ;
    logic                    r_signR;

    logic                    w_isSignedIn;
    logic [DATA_WIDTH-1:0]   w_magA;
    logic [DATA_WIDTH-1:0]   w_magB;
    logic                    w_isDivOp;
    logic [DATA_WIDTH-1:0]   w_accHi;
    logic [DATA_WIDTH-1:0]   w_accLo;
    logic [DATA_WIDTH:0]     w_mulSum;
    logic [DATA_WIDTH:0]     w_divShift;
    logic [DATA_WIDTH:0]     w_divDiff;
    logic                    w_divOk;
    logic [2*DATA_WIDTH-1:0] w_stepAcc;
    logic [2*DATA_WIDTH-1:0] w_prod;
    logic [DATA_WIDTH-1:0]   w_quot;
    logic [DATA_WIDTH-1:0]   w_rem;

    // Two's-complement negation of the most negative value wraps to itself,
    // which is exactly its unsigned magnitude.
    assign w_isSignedIn = (i_Op == OP_MULT) || (i_Op == OP_DIV);
    assign w_magA       = (w_isSignedIn && i_SrcA[DATA_WIDTH-1]) ? -i_SrcA : i_SrcA;
    assign w_magB       = (w_isSignedIn && i_SrcB[DATA_WIDTH-1]) ? -i_SrcB : i_SrcB;

    assign w_isDivOp = (r_op == OP_DIVU) || (r_op == OP_DIV);
    assign w_accHi   = r_acc[2*DATA_WIDTH-1:DATA_WIDTH];
    assign w_accLo   = r_acc[DATA_WIDTH-1:0];

    assign w_mulSum   = {1'b0, w_accHi} + {1'b0, (r_opA[0] ? r_opB : '0)};
    assign w_divShift = {w_accHi, r_opA[DATA_WIDTH-1]};
    assign w_divDiff  = w_divShift - {1'b0, r_opB};
    assign w_divOk    = ~w_divDiff[DATA_WIDTH];

    always_comb begin
        w_stepAcc = {w_mulSum, w_accLo[DATA_WIDTH-1:1]};
        if (w_isDivOp) begin
            w_stepAcc = {(w_divOk ? w_divDiff[DATA_WIDTH-1:0] : w_divShift[DATA_WIDTH-1:0]),
                         w_accLo[DATA_WIDTH-2:0], w_divOk};
        end
    end

    // r_opA is the multiplier (consumed LSB first) or the dividend (consumed MSB first).
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            r_op    <= '0;
            r_acc   <= '0;
            r_opA   <= '0;
            r_opB   <= '0;
            r_origA <= '0;
            r_signQ <= 1'b0;
            r_signR <= 1'b0;
        end else if (i_Load) begin
            r_op    <= i_Op;
            r_acc   <= '0;
            r_opA   <= w_magA;
            r_opB   <= w_magB;
            r_origA <= i_SrcA;
            r_signQ <= i_SrcA[DATA_WIDTH-1] ^ i_SrcB[DATA_WIDTH-1];
            r_signR <= i_SrcA[DATA_WIDTH-1];
        end else if (i_Step) begin
            r_acc <= w_stepAcc;
            r_opA <= w_isDivOp ? (r_opA << 1) : (r_opA >> 1);
        end
    end

    always_comb begin
        w_prod = r_acc;
        w_quot = w_accLo;
        w_rem  = w_accHi;
        if ((r_op == OP_MULT) && r_signQ) begin
            w_prod = -r_acc;
        end
        if ((r_op == OP_DIV) && r_signQ) begin
            w_quot = -w_accLo;
        end
        if ((r_op == OP_DIV) && r_signR) begin
            w_rem = -w_accHi;
        end
    end

    // A zero divisor keeps its magnitude zero, so r_opB identifies it for both signed forms.
    always_comb begin
        o_HiResult = w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
        o_LoResult = w_prod[DATA_WIDTH-1:0];
        if (w_isDivOp) begin
            if (r_opB == '0) begin
                o_HiResult = r_origA;
                o_LoResult = DIV0_QUOTIENT[DATA_WIDTH-1:0];
            end else begin
                o_HiResult = w_rem;
                o_LoResult = w_quot;
            end
        end
    end

endmodule

// File: rtl/execute_muldiv_unit.sv
// Execute-stage multi-cycle multiply/divide unit: control FSM, iteration counter,
// architectural HI/LO registers and the busy/stall request.
module execute_muldiv_unit
    import execute_muldiv_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  i_Start,
    input  logic [1:0]            i_Op,
    input  logic [DATA_WIDTH-1:0] i_SrcAE,
    input  logic [DATA_WIDTH-1:0] i_SrcBE,
    input  logic                  i_Flush,
    input  logic                  i_HIWrite,
    input  logic                  i_LOWrite,
    input  logic [DATA_WIDTH-1:0] i_WriteData,
    output logic                  o_Busy,
    output logic                  o_Done,
    output logic [DATA_WIDTH-1:0] o_HI,
    output logic [DATA_WIDTH-1:0] o_LO
);

    localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(DATA_WIDTH - 1);

    muldiv_state_e          r_state;
    muldiv_state_e          w_nextState;
    logic [CNT_WIDTH-1:0]   r_count;
    logic [DATA_WIDTH-1:0]  r_HI;
    logic [DATA_WIDTH-1:0]  r_LO;
    logic                   r_Done;
    logic                   w_load;
    logic                   w_step;
    logic                   w_fix;
    logic [DATA_WIDTH-1:0]  w_hiResult;
    logic [DATA_WIDTH-1:0]  w_loResult;

    muldiv_datapath #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_datapath (
        .i_CLK      (i_CLK),
        .i_RST      (i_RST),
        .i_Load     (w_load),
        .i_Step     (w_step),
        .i_Op       (i_Op),
        .i_SrcA     (i_SrcAE),
        .i_SrcB     (i_SrcBE),
        .o_HiResult (w_hiResult),
        .o_LoResult (w_loResult)
    );

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Flush overrides everything, including a Start in IDLE and the FIX write-back.
    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_fix       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_Start) begin
                    w_load      = 1'b1;
                    w_nextState = ST_RUN;
                end
            end
            ST_RUN: begin
                w_step = 1'b1;
                if (r_count == LAST_COUNT) begin
                    w_nextState = ST_FIX;
                end
            end
            ST_FIX: begin
                w_fix       = 1'b1;
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
        if (i_Flush) begin
            w_nextState = ST_IDLE;
            w_load      = 1'b0;
            w_step      = 1'b0;
            w_fix       = 1'b0;
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            r_count <= '0;
        end else if (w_load) begin
            r_count <= '0;
        end else if (w_step) begin
            r_count <= r_count + 1'b1;
        end
    end

    // MTHI/MTLO only land in IDLE; a Start in the same cycle is overwritten later at FIX.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            r_HI   <= '0;
            r_LO   <= '0;
            r_Done <= 1'b0;
        end else begin
            r_Done <= w_fix;
            if (w_fix) begin
                r_HI <= w_hiResult;
                r_LO <= w_loResult;
            end else if (r_state == ST_IDLE) begin
                if (i_HIWrite) begin
                    r_HI <= i_WriteData;
                end
                if (i_LOWrite) begin
                    r_LO <= i_WriteData;
                end
            end
        end
    end

    assign o_Busy = (r_state != ST_IDLE);
    assign o_Done = r_Done;
    assign o_HI   = r_HI;
    assign o_LO   = r_LO;

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Self-checking bench for execute_muldiv_unit: vector table plus random unsigned ops
// through a result scoreboard, and hand-written reset/flush/MT* sequences.
module tb_execute_muldiv_unit;

    logic        i_CLK;
    logic        i_RST;
    logic        i_Start;
    logic [1:0]  i_Op;
    logic [31:0] i_SrcAE;
    logic [31:0] i_SrcBE;
    logic        i_Flush;
    logic        i_HIWrite;
    logic        i_LOWrite;
    logic [31:0] i_WriteData;
    logic        o_Busy;
    logic        o_Done;
    logic [31:0] o_HI;
    logic [31:0] o_LO;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    localparam logic [1:0] MULTU = 2'b00;
    localparam logic [1:0] MULT  = 2'b01;
    localparam logic [1:0] DIVU  = 2'b10;
    localparam logic [1:0] DIV   = 2'b11;

    vec_t vecs[13];
    exp_t scoreboard[$];
    int   checkCount = 0;
    int   failCount  = 0;

    execute_muldiv_unit #(
        .DATA_WIDTH(32),
        .CNT_WIDTH (5)
    ) dut (
        .i_CLK       (i_CLK),
        .i_RST       (i_RST),
        .i_Start     (i_Start),
        .i_Op        (i_Op),
        .i_SrcAE     (i_SrcAE),
        .i_SrcBE     (i_SrcBE),
        .i_Flush     (i_Flush),
        .i_HIWrite   (i_HIWrite),
        .i_LOWrite   (i_LOWrite),
        .i_WriteData (i_WriteData),
        .o_Busy      (o_Busy),
        .o_Done      (o_Done),
        .o_HI        (o_HI),
        .o_LO        (o_LO)
    );

    initial i_CLK = 1'b0;
    always #5 i_CLK = ~i_CLK;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drives Start for one cycle; returns at the falling edge after the launch edge.
    task automatic launchOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        i_Op    = op;
        i_SrcAE = a;
        i_SrcBE = b;
        i_Start = 1'b1;
        @(negedge i_CLK);
        i_Start = 1'b0;
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expHi, input logic [31:0] expLo);
        exp_t e;
        e.hi = expHi;
        e.lo = expLo;
        scoreboard.push_back(e);
        launchOp(op, a, b);
    endtask

    task automatic waitResult(input string name, input bit checkLatency);
        int   busyCycles;
        exp_t e;
        busyCycles = 0;
        for (int i = 0; i < 100; i++) begin
            if (o_Done) break;
            if (o_Busy) busyCycles++;
            @(negedge i_CLK);
        end
        if (!o_Done) begin
            checkOutput({name, "_doneTimeout"}, 32'(o_Done), 32'd1);
        end
        e = scoreboard.pop_front();
        checkOutput({name, "_HI"}, o_HI, e.hi);
        checkOutput({name, "_LO"}, o_LO, e.lo);
        checkOutput({name, "_busyAtDone"}, 32'(o_Busy), 32'd0);
        if (checkLatency) begin
            checkOutput({name, "_busyCycles"}, busyCycles, 32'd33);
        end
        @(negedge i_CLK);
        checkOutput({name, "_donePulse"}, 32'(o_Done), 32'd0);
    endtask

    initial begin
        int doneSeen;
        int busySeen;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] prod;

        vecs[0]  = '{MULTU, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 32'h0000_0006};
        vecs[1]  = '{MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[2]  = '{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[3]  = '{MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[4]  = '{MULT,  32'h0000_0007, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFDD};
        vecs[5]  = '{DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[6]  = '{DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
        vecs[7]  = '{DIVU,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
        vecs[8]  = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[9]  = '{DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[10] = '{DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
        vecs[11] = '{DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[12] = '{MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};

        i_RST       = 1'b1;
        i_Start     = 1'b0;
        i_Op        = MULTU;
        i_SrcAE     = '0;
        i_SrcBE     = '0;
        i_Flush     = 1'b0;
        i_HIWrite   = 1'b0;
        i_LOWrite   = 1'b0;
        i_WriteData = '0;
        repeat (2) @(negedge i_CLK);
        checkOutput("reset_busy", 32'(o_Busy), 32'd0);
        checkOutput("reset_done", 32'(o_Done), 32'd0);
        checkOutput("reset_HI", o_HI, 32'd0);
        checkOutput("reset_LO", o_LO, 32'd0);
        i_RST = 1'b0;
        @(negedge i_CLK);

        $display("[TB] vector table");
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expHi, vecs[i].expLo);
            waitResult($sformatf("vec%0d", i), 1'b1);
        end

        $display("[TB] random unsigned operations");
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
            if (i < 4) begin
                prod = {32'd0, ra} * {32'd0, rb};
                applyStimulus(MULTU, ra, rb, prod[63:32], prod[31:0]);
            end else begin
                if (rb == 32'd0) rb = 32'd3;
                applyStimulus(DIVU, ra, rb, ra % rb, ra / rb);
            end
            waitResult($sformatf("rand%0d", i), 1'b0);
        end

        $display("[TB] reset during RUN");
        i_HIWrite   = 1'b1;
        i_WriteData = 32'h5;
        @(negedge i_CLK);
        i_HIWrite = 1'b0;
        launchOp(MULTU, 32'h1234, 32'h5678);
        repeat (9) @(negedge i_CLK);
        #2 i_RST = 1'b1;
        #1;
        checkOutput("midReset_busy", 32'(o_Busy), 32'd0);
        checkOutput("midReset_HI", o_HI, 32'd0);
        checkOutput("midReset_LO", o_LO, 32'd0);
        @(negedge i_CLK);
        i_RST = 1'b0;
        doneSeen = 0;
        busySeen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge i_CLK);
            if (o_Done) doneSeen++;
            if (o_Busy) busySeen++;
        end
        checkOutput("midReset_noDone", doneSeen, 32'd0);
        checkOutput("midReset_noBusy", busySeen, 32'd0);

        $display("[TB] flush during RUN");
        i_HIWrite   = 1'b1;
        i_WriteData = 32'hA;
        @(negedge i_CLK);
        i_HIWrite   = 1'b0;
        i_LOWrite   = 1'b1;
        i_WriteData = 32'hB;
        @(negedge i_CLK);
        i_LOWrite = 1'b0;
        launchOp(MULTU, 32'd5, 32'd6);
        for (int c = 2; c < 15; c++) begin
            i_Op    = DIV;
            i_Start = (c % 3 == 0);
            @(negedge i_CLK);
        end
        i_Start = 1'b0;
        checkOutput("flush_busyBefore", 32'(o_Busy), 32'd1);
        i_Flush = 1'b1;
        @(negedge i_CLK);
        i_Flush = 1'b0;
        checkOutput("flush_busy", 32'(o_Busy), 32'd0);
        checkOutput("flush_HI", o_HI, 32'hA);
        checkOutput("flush_LO", o_LO, 32'hB);
        doneSeen = 0;
        busySeen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge i_CLK);
            if (o_Done) doneSeen++;
            if (o_Busy) busySeen++;
        end
        checkOutput("flush_noDone", doneSeen, 32'd0);
        checkOutput("flush_noBusy", busySeen, 32'd0);

        i_Op    = MULTU;
        i_Start = 1'b1;
        i_Flush = 1'b1;
        @(negedge i_CLK);
        i_Start = 1'b0;
        i_Flush = 1'b0;
        checkOutput("flushStart_busy", 32'(o_Busy), 32'd0);
        @(negedge i_CLK);
        checkOutput("flushStart_busyLater", 32'(o_Busy), 32'd0);

        $display("[TB] MTLO with Start, MTHI while busy");
        scoreboard.push_back('{32'd0, 32'd6});
        i_LOWrite   = 1'b1;
        i_WriteData = 32'h55;
        launchOp(MULTU, 32'd2, 32'd3);
        i_LOWrite = 1'b0;
        checkOutput("mtlo_LO", o_LO, 32'h55);
        checkOutput("mtlo_busy", 32'(o_Busy), 32'd1);
        repeat (4) @(negedge i_CLK);
        i_HIWrite   = 1'b1;
        i_WriteData = 32'h99;
        @(negedge i_CLK);
        i_HIWrite = 1'b0;
        checkOutput("mthiBusy_HI", o_HI, 32'hA);
        waitResult("mtloStart", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
